// File: rtl/sd_cmd_pkg.sv
// Shared types and constants for the SD command-line arbiter.
// Holds the FSM encoding, bus widths and the round-robin pick helper.
package sd_cmd_pkg;

    localparam int CMD_W  = 40;
    localparam int RESP_W = 136;

    localparam logic REQ_HOST = 1'b0;
    localparam logic REQ_DATA = 1'b1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_RESP,
        S_ACK,
        S_ABORT,
        S_DONE
    } state_t;

    // A tie goes to whichever requester did not own the line last time.
    function automatic logic rr_pick(
        input logic v0,
        input logic v1,
        input logic last
    );
        if (v0 && v1) begin
            return ~last;
        end
        return v1 ? REQ_DATA : REQ_HOST;
    endfunction

endpackage

// File: rtl/sd_cmd_arbiter_if.sv
// Requester and physical-controller signals of the command arbiter.
// slave is the arbiter side; master is the requester/phy side.
interface sd_cmd_arbiter_if;
    import sd_cmd_pkg::*;

    logic              req0_valid;
    logic              req1_valid;
    logic [CMD_W-1:0]  req0_cmd;
    logic [CMD_W-1:0]  req1_cmd;
    logic              req0_grant;
    logic              req1_grant;
    logic              req0_done;
    logic              req1_done;
    logic              done_timeout;
    logic [RESP_W-1:0] resp_data;
    logic              abort;

    logic              phy_strobe_in;
    logic [CMD_W-1:0]  phy_cmd;
    logic              phy_ack_in;
    logic              phy_idle_in;
    logic              phy_strobe_out;
    logic              phy_ack_out;
    logic [RESP_W-1:0] phy_response;

    modport slave (
        input  req0_valid, req1_valid, req0_cmd, req1_cmd, abort,
        input  phy_strobe_out, phy_ack_out, phy_response,
        output req0_grant, req1_grant, req0_done, req1_done,
        output done_timeout, resp_data,
        output phy_strobe_in, phy_cmd, phy_ack_in, phy_idle_in
    );

    modport master (
        output req0_valid, req1_valid, req0_cmd, req1_cmd, abort,
        output phy_strobe_out, phy_ack_out, phy_response,
        input  req0_grant, req1_grant, req0_done, req1_done,
        input  done_timeout, resp_data,
        input  phy_strobe_in, phy_cmd, phy_ack_in, phy_idle_in
    );

endinterface

// File: rtl/sd_cmd_watchdog.sv
// Saturating response watchdog for the command arbiter.
// terminal is high once the count reaches TIMEOUT_CYCLES-1.
module sd_cmd_watchdog #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic sd_clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic terminal
);

    localparam int W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES - 1);

    logic [W-1:0] count;

    assign terminal = (count == LAST);

    // Count while enabled, hold at the terminal value, restart on clear.
    always_ff @(posedge sd_clock) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !terminal) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/sd_cmd_arbiter.sv
// Round-robin arbiter in front of the SD command physical controller.
// Issues one command at a time, captures the response, handles abort.
module sd_cmd_arbiter
    import sd_cmd_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic            sd_clock,
    input  logic            reset,
    sd_cmd_arbiter_if.slave bus
);

    state_t            state;
    state_t            state_nx;
    logic              owner;
    logic              last_owner;
    logic              to_flag;
    logic              wd_term;
    logic              sel;
    logic              any_req;
    logic [CMD_W-1:0]  cmd_q;
    logic [RESP_W-1:0] resp_q;

    assign any_req = bus.req0_valid | bus.req1_valid;
    assign sel     = rr_pick(bus.req0_valid, bus.req1_valid, last_owner);

    assign bus.phy_cmd   = cmd_q;
    assign bus.resp_data = resp_q;

    sd_cmd_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_wd (
        .sd_clock(sd_clock),
        .reset   (reset),
        .clear   (state == S_ISSUE),
        .enable  ((state == S_WAIT_RESP) || (state == S_ACK)),
        .terminal(wd_term)
    );

    // State register.
    always_ff @(posedge sd_clock) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state decode and state-only output decode.
    always_comb begin
        state_nx          = state;
        bus.req0_grant    = 1'b0;
        bus.req1_grant    = 1'b0;
        bus.req0_done     = 1'b0;
        bus.req1_done     = 1'b0;
        bus.done_timeout  = 1'b0;
        bus.phy_strobe_in = 1'b0;
        bus.phy_ack_in    = 1'b0;
        bus.phy_idle_in   = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (any_req) begin
                    state_nx = S_ISSUE;
                end
            end
            S_ISSUE: begin
                bus.phy_strobe_in = 1'b1;
                bus.req0_grant    = (owner == REQ_HOST);
                bus.req1_grant    = (owner == REQ_DATA);
                state_nx          = bus.abort ? S_ABORT : S_WAIT_RESP;
            end
            S_WAIT_RESP: begin
                if (bus.abort) begin
                    state_nx = S_ABORT;
                end else if (bus.phy_strobe_out) begin
                    state_nx = S_ACK;
                end else if (wd_term) begin
                    state_nx = S_ABORT;
                end
            end
            S_ACK: begin
                bus.phy_ack_in = 1'b1;
                if (bus.abort) begin
                    state_nx = S_ABORT;
                end else if (bus.phy_ack_out) begin
                    state_nx = S_DONE;
                end else if (wd_term) begin
                    state_nx = S_ABORT;
                end
            end
            S_ABORT: begin
                bus.phy_idle_in = 1'b1;
                state_nx        = S_DONE;
            end
            S_DONE: begin
                bus.req0_done    = (owner == REQ_HOST);
                bus.req1_done    = (owner == REQ_DATA);
                bus.done_timeout = to_flag;
                state_nx         = S_IDLE;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    // Owner selection, command latch and round-robin history.
    always_ff @(posedge sd_clock) begin
        if (reset) begin
            owner      <= REQ_HOST;
            last_owner <= REQ_DATA;
            cmd_q      <= '0;
        end else if ((state == S_IDLE) && any_req) begin
            owner      <= sel;
            last_owner <= sel;
            cmd_q      <= sel ? bus.req1_cmd : bus.req0_cmd;
        end
    end

    // Response capture; an abort in the same cycle suppresses it.
    always_ff @(posedge sd_clock) begin
        if (reset) begin
            resp_q <= '0;
        end else if ((state == S_WAIT_RESP) && bus.phy_strobe_out
                     && !bus.abort) begin
            resp_q <= bus.phy_response;
        end
    end

    // Completion status: set on the abort path, cleared per transaction.
    always_ff @(posedge sd_clock) begin
        if (reset) begin
            to_flag <= 1'b0;
        end else if (state == S_ABORT) begin
            to_flag <= 1'b1;
        end else if (state == S_ISSUE) begin
            to_flag <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sd_cmd_arbiter.sv
// Scoreboard bench for sd_cmd_arbiter: two instances (1024 and 16 cycles).
// Stimulus queues expected grants/dones; a monitor checks them on negedge.
module tb_sd_cmd_arbiter;
    import sd_cmd_pkg::*;

    logic sd_clock = 1'b0;
    logic reset    = 1'b1;

    always #5 sd_clock = ~sd_clock;

    sd_cmd_arbiter_if ifa();
    sd_cmd_arbiter_if ifb();

    sd_cmd_arbiter #(.TIMEOUT_CYCLES(1024)) dut_a (
        .sd_clock(sd_clock),
        .reset   (reset),
        .bus     (ifa)
    );

    sd_cmd_arbiter #(.TIMEOUT_CYCLES(16)) dut_b (
        .sd_clock(sd_clock),
        .reset   (reset),
        .bus     (ifb)
    );

    typedef struct {
        logic          owner;
        logic          to;
        logic [135:0]  resp;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    logic ga[$];
    logic gb[$];

    int total = 0;
    int bad   = 0;

    localparam logic [135:0] R_ABCD = 136'hABCD;
    localparam logic [135:0] R_BEEF = 136'hBEEF;
    localparam logic [39:0]  C0     = 40'h4000000000;
    localparam logic [39:0]  C1     = 40'h0C00000012;

    task automatic chk(input string nm, input logic [135:0] act,
                       input logic [135:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h", nm, act, req);
        end
    endtask

    task automatic push_txn(input int d, input logic own, input logic to,
                            input logic [135:0] r, input bit with_done);
        exp_t e;
        e.owner = own;
        e.to    = to;
        e.resp  = r;
        if (d == 0) begin
            ga.push_back(own);
            if (with_done) qa.push_back(e);
        end else begin
            gb.push_back(own);
            if (with_done) qb.push_back(e);
        end
    endtask

    task automatic mon(input int d, input logic g0, input logic g1,
                       input logic d0, input logic d1, input logic to,
                       input logic [135:0] rd);
        logic o;
        exp_t e;
        bit   empty;
        if (g0 === 1'b1 || g1 === 1'b1) begin
            empty = (d == 0) ? (ga.size() == 0) : (gb.size() == 0);
            if (empty) begin
                total++;
                bad++;
                $display("FAIL grant_unexpected dut%0d: actual=%b%b required=none",
                         d, g1, g0);
            end else begin
                if (d == 0) o = ga.pop_front();
                else        o = gb.pop_front();
                chk($sformatf("grant_owner dut%0d", d), {134'd0, g1, g0},
                    o ? 136'd2 : 136'd1);
            end
        end
        if (d0 === 1'b1 || d1 === 1'b1) begin
            empty = (d == 0) ? (qa.size() == 0) : (qb.size() == 0);
            if (empty) begin
                total++;
                bad++;
                $display("FAIL done_unexpected dut%0d: actual=%b%b required=none",
                         d, d1, d0);
            end else begin
                if (d == 0) e = qa.pop_front();
                else        e = qb.pop_front();
                chk($sformatf("done_owner dut%0d", d), {134'd0, d1, d0},
                    e.owner ? 136'd2 : 136'd1);
                chk($sformatf("done_timeout dut%0d", d), {135'd0, to},
                    {135'd0, e.to});
                chk($sformatf("done_resp dut%0d", d), rd, e.resp);
            end
        end
    endtask

    always @(negedge sd_clock) begin
        mon(0, ifa.req0_grant, ifa.req1_grant, ifa.req0_done,
            ifa.req1_done, ifa.done_timeout, ifa.resp_data);
        mon(1, ifb.req0_grant, ifb.req1_grant, ifb.req0_done,
            ifb.req1_done, ifb.done_timeout, ifb.resp_data);
    end

    task automatic wait_strobe_a(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge sd_clock);
            if (ifa.phy_strobe_in === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL strobe_wait: actual=none required=phy_strobe_in");
        end
    endtask

    task automatic respond_a(input int dly, input logic [135:0] r);
        repeat (dly) @(negedge sd_clock);
        ifa.phy_strobe_out = 1'b1;
        ifa.phy_response   = r;
        @(negedge sd_clock);
        chk("ack_in_after_strobe", {135'd0, ifa.phy_ack_in}, 136'd1);
        ifa.phy_strobe_out = 1'b0;
        ifa.phy_response   = '0;
        ifa.phy_ack_out    = 1'b1;
        @(negedge sd_clock);
        ifa.phy_ack_out = 1'b0;
    endtask

    task automatic chk_quiet_a(input string nm);
        chk({nm, "_strobe"}, {135'd0, ifa.phy_strobe_in}, 136'd0);
        chk({nm, "_grant"}, {134'd0, ifa.req1_grant, ifa.req0_grant}, 136'd0);
        chk({nm, "_done"}, {133'd0, ifa.done_timeout, ifa.req1_done,
                            ifa.req0_done}, 136'd0);
        chk({nm, "_ack_idle"}, {134'd0, ifa.phy_ack_in, ifa.phy_idle_in},
            136'd0);
        chk({nm, "_phy_cmd"}, {96'd0, ifa.phy_cmd}, 136'd0);
        chk({nm, "_resp"}, ifa.resp_data, 136'd0);
    endtask

    logic [39:0] fcmd [2];
    bit ok;

    initial begin
        ifa.req0_valid = 0; ifa.req1_valid = 0;
        ifa.req0_cmd = '0; ifa.req1_cmd = '0; ifa.abort = 0;
        ifa.phy_strobe_out = 0; ifa.phy_ack_out = 0; ifa.phy_response = '0;
        ifb.req0_valid = 0; ifb.req1_valid = 0;
        ifb.req0_cmd = '0; ifb.req1_cmd = '0; ifb.abort = 0;
        ifb.phy_strobe_out = 0; ifb.phy_ack_out = 0; ifb.phy_response = '0;

        repeat (3) @(negedge sd_clock);
        chk_quiet_a("reset");
        reset = 1'b0;
        @(negedge sd_clock);

        // single request, response after 50 cycles
        push_txn(0, 1'b0, 1'b0, R_ABCD, 1'b1);
        ifa.req0_valid = 1'b1;
        ifa.req0_cmd   = C0;
        @(negedge sd_clock);
        chk("single_grant0", {135'd0, ifa.req0_grant}, 136'd1);
        chk("single_strobe", {135'd0, ifa.phy_strobe_in}, 136'd1);
        chk("single_phy_cmd", {96'd0, ifa.phy_cmd}, {96'd0, C0});
        ifa.req0_valid = 1'b0;
        respond_a(49, R_ABCD);
        chk("single_done0", {135'd0, ifa.req0_done}, 136'd1);
        @(negedge sd_clock);
        chk("single_done_pulse", {135'd0, ifa.req0_done}, 136'd0);

        // strobe from phy while idle must not touch resp_data
        ifa.phy_strobe_out = 1'b1;
        ifa.phy_response   = 136'h5555;
        @(negedge sd_clock);
        ifa.phy_strobe_out = 1'b0;
        ifa.phy_response   = '0;
        @(negedge sd_clock);
        chk("idle_strobe_resp", ifa.resp_data, R_ABCD);
        chk("idle_strobe_ack", {135'd0, ifa.phy_ack_in}, 136'd0);

        // abort in the same cycle as the response strobe
        push_txn(0, 1'b1, 1'b1, R_ABCD, 1'b1);
        ifa.req1_valid = 1'b1;
        ifa.req1_cmd   = C1;
        @(negedge sd_clock);
        chk("abort_grant1", {135'd0, ifa.req1_grant}, 136'd1);
        chk("abort_phy_cmd", {96'd0, ifa.phy_cmd}, {96'd0, C1});
        ifa.req1_valid = 1'b0;
        repeat (3) @(negedge sd_clock);
        ifa.phy_strobe_out = 1'b1;
        ifa.phy_response   = 136'hDEAD;
        ifa.abort          = 1'b1;
        @(negedge sd_clock);
        chk("abort_idle_in", {135'd0, ifa.phy_idle_in}, 136'd1);
        chk("abort_no_ack", {135'd0, ifa.phy_ack_in}, 136'd0);
        ifa.phy_strobe_out = 1'b0;
        ifa.phy_response   = '0;
        ifa.abort          = 1'b0;
        @(negedge sd_clock);
        chk("abort_resp_kept", ifa.resp_data, R_ABCD);
        @(negedge sd_clock);

        // reset during WAIT_RESP
        push_txn(0, 1'b0, 1'b0, '0, 1'b0);
        ifa.req0_valid = 1'b1;
        ifa.req0_cmd   = 40'h4800000000;
        @(negedge sd_clock);
        chk("rst_mid_grant0", {135'd0, ifa.req0_grant}, 136'd1);
        ifa.req0_valid = 1'b0;
        repeat (3) @(negedge sd_clock);
        reset = 1'b1;
        @(negedge sd_clock);
        chk_quiet_a("rst_mid");
        reset = 1'b0;

        // fairness: both held for four transactions, tie first to req0
        fcmd[0] = 40'h4100000001;
        fcmd[1] = 40'h4C00000002;
        for (int i = 0; i < 4; i++) begin
            push_txn(0, 1'(i % 2), 1'b0, 136'h10000 + 136'(i), 1'b1);
        end
        ifa.req0_cmd   = fcmd[0];
        ifa.req1_cmd   = fcmd[1];
        ifa.req0_valid = 1'b1;
        ifa.req1_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wait_strobe_a(ok);
            if (!ok) break;
            chk($sformatf("fair_phy_cmd%0d", i), {96'd0, ifa.phy_cmd},
                {96'd0, fcmd[i % 2]});
            if (i == 3) begin
                ifa.req0_valid = 1'b0;
                ifa.req1_valid = 1'b0;
            end
            respond_a(2, 136'h10000 + 136'(i));
        end
        ifa.req0_valid = 1'b0;
        ifa.req1_valid = 1'b0;
        repeat (3) @(negedge sd_clock);

        // timeout with 16-cycle watchdog, phy never answers
        push_txn(1, 1'b0, 1'b1, '0, 1'b1);
        ifb.req0_valid = 1'b1;
        ifb.req0_cmd   = C0;
        @(negedge sd_clock);
        chk("to_strobe_c1", {135'd0, ifb.phy_strobe_in}, 136'd1);
        ifb.req0_valid = 1'b0;
        repeat (16) @(negedge sd_clock);
        chk("to_idle_c17", {135'd0, ifb.phy_idle_in}, 136'd0);
        @(negedge sd_clock);
        chk("to_idle_c18", {135'd0, ifb.phy_idle_in}, 136'd1);
        @(negedge sd_clock);
        chk("to_done_c19", {134'd0, ifb.req0_done, ifb.done_timeout},
            136'd3);
        chk("to_resp_kept", ifb.resp_data, 136'd0);
        @(negedge sd_clock);

        // response strobe on the watchdog terminal cycle wins
        push_txn(1, 1'b0, 1'b0, R_BEEF, 1'b1);
        ifb.req0_valid = 1'b1;
        @(negedge sd_clock);
        chk("race_grant0", {135'd0, ifb.req0_grant}, 136'd1);
        ifb.req0_valid = 1'b0;
        repeat (16) @(negedge sd_clock);
        ifb.phy_strobe_out = 1'b1;
        ifb.phy_response   = R_BEEF;
        @(negedge sd_clock);
        chk("race_ack_in", {134'd0, ifb.phy_ack_in, ifb.phy_idle_in},
            136'd2);
        ifb.phy_strobe_out = 1'b0;
        ifb.phy_response   = '0;
        ifb.phy_ack_out    = 1'b1;
        @(negedge sd_clock);
        ifb.phy_ack_out = 1'b0;
        chk("race_done_ok", {134'd0, ifb.req0_done, ifb.done_timeout},
            136'd2);
        chk("race_resp", ifb.resp_data, R_BEEF);

        repeat (4) @(negedge sd_clock);
        chk("left_done_a", 136'(qa.size()), 136'd0);
        chk("left_done_b", 136'(qb.size()), 136'd0);
        chk("left_grant_a", 136'(ga.size()), 136'd0);
        chk("left_grant_b", 136'(gb.size()), 136'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sd_cmd_arbiter.md
# sd_cmd_arbiter

Arbitrates access to the single SD command-line physical controller between two command sources: the host register interface (requester 0) and the data-transfer controller (requester 1, e.g. stop/status commands). It performs round-robin grant, drives the physical controller's strobe/ack handshake, and captures the 136-bit response. A response watchdog and a host abort force the physical controller back to idle. It sits between the command requesters and the command physical controller, in the `sd_clock` domain.

## Interface
- `TIMEOUT_CYCLES`, 1024: cycles allowed in WAIT_RESP plus ACK before abort; legal range ≥ 2.
- `sd_clock` in 1: sole clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `req0_valid`, `req1_valid` in 1 each: request pending; level, held until grant.
- `req0_cmd`, `req1_cmd` in 40 each: command frame; stable while valid.
- `req0_grant`, `req1_grant` out 1 each: one-cycle pulse when the request is taken.
- `req0_done`, `req1_done` out 1 each: one-cycle pulse when the transaction ends.
- `done_timeout` out 1: qualifies the done pulse; 1 = timeout or abort, no valid response.
- `resp_data` out 136: last captured response; held until the next capture.
- `abort` in 1: host abort of the current transaction.
- `phy_strobe_in` out 1: request strobe to the physical controller.
- `phy_cmd` out 40: command to the physical controller; registered, held for the whole transaction.
- `phy_ack_in` out 1: response acknowledge to the physical controller.
- `phy_idle_in` out 1: forces the physical controller to idle.
- `phy_strobe_out` in 1: response-ready pulse from the physical controller.
- `phy_ack_out` in 1: ack echo from the physical controller.
- `phy_response` in 136: response from the physical controller, valid while `phy_strobe_out`=1.

## Operation
- States: IDLE, ISSUE, WAIT_RESP, ACK, ABORT, DONE.
- **IDLE**
  - If either valid is high: select the owner, latch `phy_cmd` from the selected cmd, go to ISSUE.
  - Otherwise stay.
- **Round-robin selection**
  - If exactly one requester is valid, it wins.
  - If both are valid, the requester not recorded in `last_owner` wins.
  - `last_owner` updates on every grant; reset value is 1, so requester 0 wins the first tie.
- **ISSUE**
  - `phy_strobe_in`=1 and the owner's grant=1 for exactly one cycle.
  - Clear the watchdog, then go to WAIT_RESP.
- **WAIT_RESP**
  - `phy_strobe_out`=1: capture `phy_response` into `resp_data`, go to ACK.
  - Else if watchdog = TIMEOUT_CYCLES-1: go to ABORT.
- **ACK**
  - `phy_ack_in`=1.
  - `phy_ack_out`=1: go to DONE with status OK.
  - Else if watchdog terminal: go to ABORT.
- **ABORT**
  - `phy_idle_in`=1 for one cycle, then go to DONE with status timeout.
- **DONE**
  - The owner's done=1 and `done_timeout` set to the status, for one cycle.
  - Go to IDLE.
- **Watchdog**
  - Counter width is clog2(TIMEOUT_CYCLES).
  - Increments every cycle in WAIT_RESP and ACK; saturates at terminal; cleared in ISSUE.
- **abort input**
  - In ISSUE, WAIT_RESP or ACK: next state is ABORT.
  - Ignored in IDLE, ABORT and DONE.
- **Priority for simultaneous events**
  - abort beats `phy_strobe_out` and `phy_ack_out`.
  - `phy_strobe_out`/`phy_ack_out` beat watchdog terminal.
- **Requests while busy:** stay pending (level); none are lost. The non-owner is granted first on the next IDLE.
- **`phy_strobe_out` outside WAIT_RESP:** ignored; `resp_data` unchanged.

## Timing
- **Reset values**
  - State IDLE; `last_owner`=1; watchdog 0.
  - `resp_data`=0 and `phy_cmd`=0.
  - Every strobe, grant, done, ack and idle output = 0.
- **Reset mid-transaction:** IDLE on the next edge, no done pulse, `phy_idle_in` not asserted (the physical controller is reset by its own `reset`).
- **Latency**
  - Valid seen in IDLE at cycle 0 → grant and `phy_strobe_in` at cycle 1.
  - `phy_strobe_out` at cycle k → `phy_ack_in` at k+1 (`phy_ack_out` returns the same cycle) → done at k+2 → IDLE at k+3.
  - Earliest next grant is k+4.
- **Timeout:** `phy_strobe_in` at cycle 1 → `phy_idle_in` at cycle TIMEOUT_CYCLES+2 → done with `done_timeout`=1 at TIMEOUT_CYCLES+3.
- **Output source:** all outputs are decoded from registered state only; no combinational path from inputs to outputs.

## Structure
- **Package `sd_cmd_pkg`:** state encoding, CMD_W=40, RESP_W=136, REQ_HOST=0, REQ_DATA=1.
- **Sub-module `sd_cmd_watchdog`:** parameterised saturating counter with `clear`, `enable` and `terminal` outputs.
- **Top level:** arbiter FSM, round-robin bit and response register.

## Test plan
- **Single request:** req0 valid with cmd 40'h4000000000, physical-controller model responds after 50 cycles with 136'hABCD.
  - → grant0 at cycle 1; `phy_ack_in` one cycle after the strobe; done0 with `done_timeout`=0; `resp_data`=136'hABCD.
- **Fairness:** both valid continuously for 4 transactions.
  - → grant order 0,1,0,1; each done pulse goes to the matching requester.
- **Timeout:** TIMEOUT_CYCLES=16, model never responds.
  - → `phy_idle_in` pulse at cycle 18; done0 with `done_timeout`=1 at cycle 19; `resp_data` unchanged.
- **Abort:** abort asserted in the same cycle as `phy_strobe_out`.
  - → ABORT taken, response not captured, done with `done_timeout`=1.
- **Watchdog race:** `phy_strobe_out` on the watchdog terminal cycle.
  - → response captured, done with `done_timeout`=0.
- **Reset mid-transaction:** reset asserted during WAIT_RESP.
  - → all outputs 0 next cycle, no done pulse, the next tie is granted to requester 0.
